mem_mirror_wr_buf: RTL and testbench
====================================

MEM_MIRROR_WR_BUF -- requirements
Module: mem_mirror_wr_buf

Interface
REQ-001 Parameter DEPTH, 8, number of FIFO entries; power of two, minimum 2.
REQ-002 Parameter SCREEN_BASE, 15'h4000, first data address mirrored to the framebuffer.
REQ-003 Parameter SCREEN_WORDS, 8192, number of mirrored words.
REQ-004 clk  in  1  single clock for all state.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 write_m  in  1  CPU data-memory write strobe, registered CPU output.
REQ-007 data_addr  in  15  CPU data-memory write address.
REQ-008 out_m  in  16  CPU data-memory write data.
REQ-009 fb_busy  in  1  VGA read owns the framebuffer port this cycle; no pop allowed.
REQ-010 clr_req  in  1  single-cycle request to zero the whole framebuffer.
REQ-011 fb_wr_en  out  1  framebuffer write strobe.
REQ-012 fb_wr_addr  out  13  framebuffer word address, data_addr minus SCREEN_BASE.
REQ-013 fb_wr_data  out  16  framebuffer write data.
REQ-014 clr_done  out  1  one-cycle pulse after the last clear write.
REQ-015 fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow  out  1  sticky flag; set on any dropped write.
REQ-017 drop_cnt  out  16  dropped-write count; saturates at 16'hFFFF.

Function
REQ-018 Push candidate: write_m=1 and SCREEN_BASE <= data_addr < SCREEN_BASE+SCREEN_WORDS; all other writes are ignored and are not counted.
REQ-019 Pop condition: level>0, fb_busy=0, and FSM in S_IDLE or S_DRAIN. The head is removed at that clock edge and fb_wr_en/addr/data are driven, registered, during the following cycle only.
REQ-020 Minimum latency for write_m in cycle N into an empty FIFO with fb_busy=0 is fb_wr_en high in cycle N+2.
REQ-021 Coalesce: a push candidate whose address equals the most recently pushed entry overwrites that entry's data with no level change. This applies only when that entry is not being popped in the same cycle; otherwise a normal push occurs.
REQ-022 Full with no pop: the push candidate is dropped, overflow is set, and drop_cnt increments. A coalescing candidate is never dropped.
REQ-023 Full with simultaneous pop: the push is accepted and level stays DEPTH.
REQ-024 Level and pointers wrap modulo DEPTH; level never exceeds DEPTH and never goes below 0.
REQ-025 Entry order is strictly FIFO; framebuffer write order equals CPU write order after coalescing.
REQ-026 FSM states:
  - S_IDLE: on clr_req go to S_DRAIN.
  - S_DRAIN: pop normally until level=0, then go to S_CLEAR with clear counter=0.
  - S_CLEAR: each fb_busy=0 cycle writes 16'h0000 at counter and increments it. After writing address SCREEN_WORDS-1, go to S_IDLE and pulse clr_done in the cycle after that write.
REQ-027 In S_CLEAR the FIFO keeps accepting pushes but never pops; those pushes drain after return to S_IDLE.
REQ-028 clr_req outside S_IDLE is ignored.
REQ-029 fb_wr_en is never high in a cycle following a fb_busy=1 pop-decision cycle.

Reset
REQ-030 Asserting resetN low immediately and asynchronously clears, even mid-clear or mid-drain:
  - FIFO pointers and fifo_level to 0
  - FSM to S_IDLE
  - fb_wr_en, clr_done, overflow to 0
  - fb_wr_addr, fb_wr_data, drop_cnt, clear counter to 0
  No framebuffer write occurs while resetN=0.
REQ-031 FIFO storage array is not reset.

Structure
REQ-032 cpu_pkg holds the state enum t_mirror_state (S_IDLE, S_DRAIN, S_CLEAR) plus the constants SCREEN_BASE_ADDR, SCREEN_WORDS and MIRROR_FIFO_DEPTH.
REQ-033 Storage, pointers and level live in one sub-module, mirror_fifo, with push/pop/coalesce ports. Range check, FSM, counters and output registers live in the top.

Verification
REQ-034 Write 0x4000<=0xAAAA in cycle 0, fb_busy=0 -> fb_wr_en=1, addr 0, data 0xAAAA in cycle 2 only.
REQ-035 Write 0x3FFF and 0x6000 -> no fb_wr_en, level stays 0, drop_cnt stays 0.
REQ-036 fb_busy=1, 10 distinct screen writes with DEPTH=8 -> level=8, drop_cnt=2, overflow=1. Release fb_busy -> the first 8 data values are written in order.
REQ-037 Consecutive writes 0x4005<=1 then 0x4005<=2 while fb_busy=1 -> level=1; after release, a single write of 2 to address 5.
REQ-038 clr_req with 3 queued entries -> the 3 entries are written first, then 8192 zero writes at 0..8191. A write pushed during the clear appears after them; clr_done pulses once.
REQ-039 resetN low mid-clear at counter 100 -> all outputs 0 and state S_IDLE; no further zero writes after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : shared types and constants for the framebuffer mirror write path
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } t_mirror_state;

  localparam logic [14:0] SCREEN_BASE_ADDR  = 15'h4000;
  localparam int unsigned SCREEN_WORDS      = 8192;
  localparam int unsigned MIRROR_FIFO_DEPTH = 8;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } t_fb_entry;

endpackage

`default_nettype wire

// File: rtl/mirror_fifo.sv
// ---------------------------------------------------------------------------
// mirror_fifo : entry storage, pointers and occupancy for the mirror buffer
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mirror_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = MIRROR_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   coalesce,
  input  t_fb_entry              wr_entry,
  output t_fb_entry              head,
  output logic [12:0]            tail_addr,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PW = $clog2(DEPTH);

  t_fb_entry      r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  w_tail_ptr;

  assign w_tail_ptr = r_wr_ptr - PW'(1);
  assign head       = r_mem[r_rd_ptr];
  assign tail_addr  = r_mem[w_tail_ptr].addr;

  // Coalescing rewrites only the data of the newest entry; push and coalesce are exclusive.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= wr_entry;
    end else if (coalesce) begin
      r_mem[w_tail_ptr].data <= wr_entry.data;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      level    <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_mirror_wr_buf.sv
// ---------------------------------------------------------------------------
// mem_mirror_wr_buf : buffers CPU screen writes and replays them into the
//                     framebuffer port around VGA reads; also bulk-clears it
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_mirror_wr_buf
  import cpu_pkg::t_mirror_state;
  import cpu_pkg::S_IDLE;
  import cpu_pkg::S_DRAIN;
  import cpu_pkg::S_CLEAR;
  import cpu_pkg::t_fb_entry;
#(
  parameter int unsigned DEPTH        = cpu_pkg::MIRROR_FIFO_DEPTH,
  parameter logic [14:0] SCREEN_BASE  = cpu_pkg::SCREEN_BASE_ADDR,
  parameter int unsigned SCREEN_WORDS = cpu_pkg::SCREEN_WORDS
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   write_m,
  input  logic [14:0]            data_addr,
  input  logic [15:0]            out_m,
  input  logic                   fb_busy,
  input  logic                   clr_req,
  output logic                   fb_wr_en,
  output logic [12:0]            fb_wr_addr,
  output logic [15:0]            fb_wr_data,
  output logic                   clr_done,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);

  localparam int unsigned LW           = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] c_full_lvl = LW'(DEPTH);
  localparam logic [15:0] c_screen_lo  = 16'(SCREEN_BASE);
  localparam logic [15:0] c_screen_hi  = 16'(SCREEN_BASE) + 16'(SCREEN_WORDS);
  localparam logic [12:0] c_last_word  = 13'(SCREEN_WORDS - 1);

  t_mirror_state r_state;
  logic [12:0]   r_clr_cnt;
  logic          r_clr_last;

  logic          w_cand;
  logic          w_pop;
  logic          w_push;
  logic          w_coalesce;
  logic          w_drop;
  logic          w_full;
  logic          w_tail_hit;
  logic [12:0]   w_off;
  logic [12:0]   w_tail_addr;
  t_fb_entry     w_head;
  t_fb_entry     w_wr_entry;

  assign w_off      = 13'(data_addr - SCREEN_BASE);
  assign w_cand     = write_m && ({1'b0, data_addr} >= c_screen_lo)
                              && ({1'b0, data_addr} <  c_screen_hi);
  assign w_full     = (fifo_level == c_full_lvl);
  assign w_pop      = (fifo_level != '0) && !fb_busy
                      && ((r_state == S_IDLE) || (r_state == S_DRAIN));
  assign w_tail_hit = (fifo_level != '0) && (w_tail_addr == w_off);

  // A lone entry leaving this cycle cannot absorb the write; it becomes a fresh push.
  assign w_coalesce = w_cand && w_tail_hit && !(w_pop && (fifo_level == LW'(1)));
  assign w_push     = w_cand && !w_coalesce && (!w_full || w_pop);
  assign w_drop     = w_cand && !w_coalesce && w_full && !w_pop;

  assign w_wr_entry = '{addr: w_off, data: out_m};

  mirror_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetN    (resetN),
    .push      (w_push),
    .pop       (w_pop),
    .coalesce  (w_coalesce),
    .wr_entry  (w_wr_entry),
    .head      (w_head),
    .tail_addr (w_tail_addr),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_clr_cnt  <= '0;
      r_clr_last <= 1'b0;
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
      clr_done   <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      fb_wr_en   <= 1'b0;
      r_clr_last <= 1'b0;
      clr_done   <= r_clr_last;

      if (w_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end

      if (w_pop) begin
        fb_wr_en   <= 1'b1;
        fb_wr_addr <= w_head.addr;
        fb_wr_data <= w_head.data;
      end

      case (r_state)
        S_IDLE: begin
          if (clr_req) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (fifo_level == '0) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        S_CLEAR: begin
          if (!fb_busy) begin
            fb_wr_en   <= 1'b1;
            fb_wr_addr <= r_clr_cnt;
            fb_wr_data <= 16'h0000;
            r_clr_cnt  <= r_clr_cnt + 13'd1;
            if (r_clr_cnt == c_last_word) begin
              r_state    <= S_IDLE;
              r_clr_last <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_mirror_wr_buf.sv
// ---------------------------------------------------------------------------
// tb_mem_mirror_wr_buf : directed self-checking bench for mem_mirror_wr_buf
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_mirror_wr_buf;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        write_m = 1'b0;
  logic [14:0] data_addr = '0;
  logic [15:0] out_m = '0;
  logic        fb_busy = 1'b0;
  logic        clr_req = 1'b0;
  logic        fb_wr_en;
  logic [12:0] fb_wr_addr;
  logic [15:0] fb_wr_data;
  logic        clr_done;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_cnt;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [12:0] wa[$];
  logic [15:0] wd[$];
  int          clr_pulses = 0;
  int          cd_pos = -1;

  always #5 clk = ~clk;

  mem_mirror_wr_buf dut (
    .clk        (clk),
    .resetN     (resetN),
    .write_m    (write_m),
    .data_addr  (data_addr),
    .out_m      (out_m),
    .fb_busy    (fb_busy),
    .clr_req    (clr_req),
    .fb_wr_en   (fb_wr_en),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data),
    .clr_done   (clr_done),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  // Framebuffer write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (clr_done) begin
      clr_pulses++;
      cd_pos = wa.size();
    end
    if (fb_wr_en) begin
      wa.push_back(fb_wr_addr);
      wd.push_back(fb_wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    write_m   = 1'b1;
    data_addr = a;
    out_m     = d;
    cyc();
    write_m   = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    logic found;
    int   zerr;

    // Reset state
    cyc(2);
    chk("rst_en", 32'(fb_wr_en), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_clr_done", 32'(clr_done), 32'd0);
    resetN = 1'b1;
    cyc();

    // Single write: visible two cycles later, for one cycle
    write_m = 1'b1; data_addr = 15'h4000; out_m = 16'hAAAA;
    chk("lat_c0_en", 32'(fb_wr_en), 32'd0);
    cyc();
    write_m = 1'b0;
    chk("lat_c1_en", 32'(fb_wr_en), 32'd0);
    chk("lat_c1_level", 32'(fifo_level), 32'd1);
    cyc();
    chk("lat_c2_en", 32'(fb_wr_en), 32'd1);
    chk("lat_c2_addr", 32'(fb_wr_addr), 32'h0);
    chk("lat_c2_data", 32'(fb_wr_data), 32'hAAAA);
    cyc();
    chk("lat_c3_en", 32'(fb_wr_en), 32'd0);

    // Out-of-range writes ignored; last in-range word accepted
    clear_log();
    wr(15'h3FFF, 16'h1111);
    wr(15'h6000, 16'h2222);
    cyc(3);
    chk("oor_writes", 32'(wa.size()), 32'd0);
    chk("oor_level", 32'(fifo_level), 32'd0);
    chk("oor_drop", 32'(drop_cnt), 32'd0);
    wr(15'h5FFF, 16'h1234);
    cyc(2);
    chk("top_word_cnt", 32'(wa.size()), 32'd1);
    chk("top_word_addr", 32'(wa[0]), 32'h1FFF);
    chk("top_word_data", 32'(wd[0]), 32'h1234);

    // Coalesce on repeated address
    clear_log();
    fb_busy = 1'b1;
    wr(15'h4005, 16'h0001);
    wr(15'h4005, 16'h0002);
    cyc();
    chk("coal_level", 32'(fifo_level), 32'd1);
    fb_busy = 1'b0;
    cyc(4);
    chk("coal_cnt", 32'(wa.size()), 32'd1);
    chk("coal_addr", 32'(wa[0]), 32'h5);
    chk("coal_data", 32'(wd[0]), 32'h2);

    // Overflow: 10 writes into 8 entries, coalesce while full, push with pop while full
    clear_log();
    fb_busy = 1'b1;
    for (int i = 0; i < 10; i++) wr(15'h4010 + 15'(i), 16'h0100 + 16'(i));
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_drop", 32'(drop_cnt), 32'd2);
    chk("full_ovf", 32'(overflow), 32'd1);
    wr(15'h4017, 16'h0777);
    chk("full_coal_drop", 32'(drop_cnt), 32'd2);
    chk("full_coal_level", 32'(fifo_level), 32'd8);
    chk("busy_no_write", 32'(wa.size()), 32'd0);
    fb_busy = 1'b0;
    wr(15'h4020, 16'h01FF);
    chk("full_pushpop_level", 32'(fifo_level), 32'd8);
    chk("full_pushpop_drop", 32'(drop_cnt), 32'd2);
    cyc(12);
    chk("full_drain_cnt", 32'(wa.size()), 32'd9);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("full_addr%0d", i), 32'(wa[i]), 32'h10 + 32'(i));
      chk($sformatf("full_data%0d", i), 32'(wd[i]), (i == 7) ? 32'h777 : 32'h100 + 32'(i));
    end
    chk("full_last_addr", 32'(wa[8]), 32'h20);
    chk("full_last_data", 32'(wd[8]), 32'h1FF);
    chk("full_drain_level", 32'(fifo_level), 32'd0);

    // Clear with queued entries, a push during the clear, and an ignored clr_req
    clear_log();
    clr_pulses = 0;
    fb_busy = 1'b1;
    wr(15'h4030, 16'h0030);
    wr(15'h4031, 16'h0031);
    wr(15'h4032, 16'h0032);
    clr_req = 1'b1; fb_busy = 1'b0;
    cyc();
    clr_req = 1'b0;
    cyc(20);
    wr(15'h4040, 16'hBEEF);
    cyc(40);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int k = 0; k < 9000 && !(clr_pulses > 0 && wa.size() >= 8196); k++) cyc();
    cyc(5);
    chk("clr_total", 32'(wa.size()), 32'd8196);
    if (wa.size() == 8196) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("clr_pre_addr%0d", i), 32'(wa[i]), 32'h30 + 32'(i));
        chk($sformatf("clr_pre_data%0d", i), 32'(wd[i]), 32'h30 + 32'(i));
      end
      zerr = 0;
      for (int i = 0; i < 8192; i++)
        if (wa[3 + i] !== 13'(i) || wd[3 + i] !== 16'h0) zerr++;
      chk("clr_zero_seq_errs", 32'(zerr), 32'd0);
      chk("clr_post_addr", 32'(wa[8195]), 32'h40);
      chk("clr_post_data", 32'(wd[8195]), 32'hBEEF);
    end
    chk("clr_done_pulses", 32'(clr_pulses), 32'd1);
    chk("clr_done_pos", 32'(cd_pos), 32'd8195);

    // Asynchronous reset in the middle of a clear
    clear_log();
    clr_pulses = 0;
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (fb_wr_en && fb_wr_addr == 13'd100) found = 1'b1;
      else cyc();
    end
    chk("midclr_reached", 32'(found), 32'd1);
    #2 resetN = 1'b0;
    #1;
    chk("arst_en", 32'(fb_wr_en), 32'd0);
    chk("arst_addr", 32'(fb_wr_addr), 32'd0);
    chk("arst_data", 32'(fb_wr_data), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    chk("arst_clr_done", 32'(clr_done), 32'd0);
    chk("arst_state", 32'(dut.r_state), 32'(S_IDLE));
    cyc(3);
    resetN = 1'b1;
    clear_log();
    cyc(50);
    chk("post_rst_writes", 32'(wa.size()), 32'd0);
    chk("post_rst_clr_done", 32'(clr_pulses), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
